// File: rtl/led_test_status_ctrl_pkg.sv
// Shared types, constants and helper functions for the stress-test status LED controller.
package led_status_pkg;

  // Test sequencer states; encoding 2'd3 is unused and steers back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_e;

  // Largest channel count the helper functions accept.
  localparam int MAX_CHAN = 16;

  // Default blink half-periods in clk cycles (normal and failure rate).
  localparam int DEF_RUN_DIV = 25000000;
  localparam int DEF_ERR_DIV = 6250000;

  // Index of the lowest set bit; returns 0 when no bit is set.
  function automatic logic [3:0] lowest_set_idx(input logic [MAX_CHAN-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_CHAN - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Number of set bits (0..16).
  function automatic logic [4:0] popcount(input logic [MAX_CHAN-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_CHAN; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/led_test_status_ctrl_prescaler.sv
// Blink prescaler: square wave with a half-period of div clk cycles.
// restart re-zeroes the count without touching the output level, so the
// first half-period after a restart is always a full div cycles.
module led_blink_prescaler #(
  parameter int DIV_W = 25
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] div,
  input  logic             restart,
  output logic             blink
);

  logic [DIV_W-1:0] cnt_q;
  logic             blink_q;

  // Count 0..div-1, toggle the output at terminal count.
  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else if (restart) begin
      cnt_q   <= '0;
    end else if (cnt_q == div - DIV_W'(1)) begin
      cnt_q   <= '0;
      blink_q <= ~blink_q;
    end else begin
      cnt_q   <= cnt_q + DIV_W'(1);
    end
  end

  assign blink = blink_q;

endmodule

// File: rtl/led_test_status_ctrl.sv
// Test sequencer for the 15-segment status LED driver: runs IDLE/RUN/FAIL,
// drives seg_en/err_det/blink_speed, latches sticky error info and counts passes.
module led_test_status_ctrl
  import led_status_pkg::*;
#(
  parameter int N_CHAN  = 4,
  parameter int IDX_W   = 2,
  parameter int DIV_W   = 25,
  parameter int RUN_DIV = DEF_RUN_DIV,
  parameter int ERR_DIV = DEF_ERR_DIV,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              test_start,
  input  logic              test_stop,
  input  logic              clear_err,
  input  logic [N_CHAN-1:0] chan_en,
  input  logic [N_CHAN-1:0] chan_err,
  input  logic [N_CHAN-1:0] chan_pass,
  output logic              seg_en,
  output logic              err_det,
  output logic              blink_speed,
  output logic [N_CHAN-1:0] err_chan,
  output logic [IDX_W-1:0]  err_first,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic              busy
);

  // Sum is wide enough for a saturated count plus a full popcount.
  localparam int              SUM_W   = ((CNT_W > 5) ? CNT_W : 5) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  logic                seg_en_q, err_det_q, busy_q;
  logic [N_CHAN-1:0]   err_chan_q;
  logic [IDX_W-1:0]    err_first_q, err_first_d;
  logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic [SUM_W-1:0]    pass_sum;
  logic [N_CHAN-1:0]   err_qual, pass_qual;
  logic [DIV_W-1:0]    blink_div;
  logic                blink_restart;

  // Disabled channels are invisible to both error detection and pass counting.
  assign err_qual  = chan_err & chan_en;
  assign pass_qual = chan_pass & chan_en;

  assign err_first_d = IDX_W'(lowest_set_idx(MAX_CHAN'(err_qual)));
  assign pass_sum    = SUM_W'(pass_cnt_q) + SUM_W'(popcount(MAX_CHAN'(pass_qual)));
  assign pass_cnt_d  = (pass_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(pass_sum);

  // Next-state selection; errors outrank stop/start while running.
  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (test_start) state_d = RUN;
      RUN: begin
        if (|err_qual)      state_d = FAIL;
        else if (test_stop) state_d = IDLE;
      end
      FAIL:    if (clear_err) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with outputs decoded from the next state, plus sticky capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      seg_en_q    <= 1'b0;
      err_det_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_chan_q  <= '0;
      err_first_q <= '0;
      pass_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      seg_en_q  <= (state_d == RUN) || (state_d == FAIL);
      err_det_q <= (state_d == FAIL);
      busy_q    <= (state_d == RUN);
      case (state_q)
        IDLE: begin
          if (test_start) begin
            pass_cnt_q  <= '0;
            err_chan_q  <= '0;
            err_first_q <= '0;
          end
        end
        RUN: begin
          pass_cnt_q <= pass_cnt_d;
          if (|err_qual) begin
            err_chan_q  <= err_qual;
            err_first_q <= err_first_d;
          end
        end
        FAIL: begin
          if (clear_err) begin
            err_chan_q  <= '0;
            err_first_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Blink rate follows the settled state; any transition restarts the half-period.
  assign blink_div     = (state_q == FAIL) ? DIV_W'(ERR_DIV) : DIV_W'(RUN_DIV);
  assign blink_restart = (state_d != state_q);

  led_blink_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .resetn  (resetn),
    .div     (blink_div),
    .restart (blink_restart),
    .blink   (blink_speed)
  );

  assign seg_en    = seg_en_q;
  assign err_det   = err_det_q;
  assign busy      = busy_q;
  assign err_chan  = err_chan_q;
  assign err_first = err_first_q;
  assign pass_cnt  = pass_cnt_q;

endmodule

// File: doc/led_test_status_ctrl.md
Name: led_test_status_ctrl

Overview:
- Sequencing controller for the 15-segment status LED driver in the SDRAM stress-test design.
- Collects per-channel pass/error status from N_CHAN stress-test channels.
- Runs the test state machine (idle/run/fail) and generates the driver's seg_en, err_det and blink_speed inputs.
- blink_speed is a prescaled square wave whose rate depends on the current state.
- Latches sticky error information (which channels failed, which channel failed first) and counts completed pass iterations for debug readback.

Parameters:
- N_CHAN, 4: number of stress-test channels monitored; 1..16.
- IDX_W, 2: width of the channel index; must equal ceil(log2(N_CHAN)), minimum 1.
- DIV_W, 25: width of the blink prescaler counter.
- RUN_DIV, 25000000: clk cycles per blink_speed half-period in IDLE/RUN; range 2..2^DIV_W-1.
- ERR_DIV, 6250000: clk cycles per blink_speed half-period in FAIL; range 2..2^DIV_W-1.
- CNT_W, 16: width of the pass counter.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- test_start  in  1  single-cycle pulse; starts the test from IDLE
- test_stop  in  1  single-cycle pulse; aborts RUN back to IDLE
- clear_err  in  1  single-cycle pulse; leaves FAIL and clears sticky state
- chan_en  in  N_CHAN  per-channel enable mask; sampled every cycle
- chan_err  in  N_CHAN  per-channel error strobe, level or pulse
- chan_pass  in  N_CHAN  per-channel pass-complete pulse
- seg_en  out  1  display enable to the LED driver
- err_det  out  1  error indication to the LED driver
- blink_speed  out  1  blink square wave to the LED driver
- err_chan  out  N_CHAN  sticky failing-channel vector
- err_first  out  IDX_W  index of the first failing channel
- pass_cnt  out  CNT_W  saturating count of pass pulses
- busy  out  1  high in RUN

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, prescaler=0.
  - All outputs 0: blink_speed=0, seg_en=0, err_det=0, err_chan=0, err_first=0, pass_cnt=0, busy=0.
  - Reset mid-operation aborts immediately; no state survives.
- State encoding in package: IDLE=0, RUN=1, FAIL=2. Value 3 is illegal and recovers to IDLE on the next clock.
- Qualified inputs: e = chan_err & chan_en; p = chan_pass & chan_en.
- Transitions (priority top-down within each state):
  - IDLE:
    - test_start -> RUN; clear pass_cnt, err_chan and err_first on entry.
    - Otherwise hold.
  - RUN:
    - |e -> FAIL. Error wins over test_stop and test_start in the same cycle.
    - Else test_stop -> IDLE.
    - Else hold. test_start in RUN is ignored.
  - FAIL:
    - clear_err -> IDLE; clear err_chan and err_first.
    - Else hold. chan_err, test_start and test_stop are ignored.
- Registered outputs (updated on the clock edge that enters the state, so they follow the state with no extra latency):
  - seg_en=1 in RUN and FAIL; 0 in IDLE.
  - err_det=1 only in FAIL.
  - busy=1 only in RUN.
- Sticky error capture, on the RUN->FAIL edge:
  - err_chan <= e.
  - err_first <= lowest set index of e when several channels fail together.
- Pass counting, in RUN only:
  - pass_cnt increments by popcount(p) each cycle.
  - Saturates at 2^CNT_W-1; no wrap.
  - When an error and a pass arrive in the same cycle, the pass is still counted.
- Blink prescaler:
  - Active divisor = ERR_DIV in FAIL, RUN_DIV otherwise.
  - Counter counts 0..div-1. At div-1 it returns to 0 and blink_speed toggles.
  - On any state change the counter clears to 0 and blink_speed keeps its level, so the first half-period in the new state is a full div cycles.
  - Rising edges of blink_speed occur every 2*div cycles.
- Interaction with the LED driver: blink_speed runs continuously, including in IDLE, so the driver sees rising edges and advances its running pattern once seg_en is high.
- No combinational path from any input to any output.

Decomposition:
- Package led_status_pkg holds:
  - state localparams (IDLE, RUN, FAIL),
  - default divisor constants,
  - a function for lowest-set-bit index,
  - a function for popcount.
- One sub-module, led_blink_prescaler: ports clk, resetn, div, restart; output blink. Handles counter, terminal count and toggle.

Test Plan (RUN_DIV=8, ERR_DIV=2, N_CHAN=4, CNT_W=4):
- Reset release -> all outputs 0. blink_speed first rises 8 cycles after release, then every 16 cycles; seg_en=0.
- test_start pulse, then chan_pass=4'b0011 for 9 cycles -> busy=1, seg_en=1 one cycle after start; pass_cnt saturates at 15, no wrap.
- In RUN, chan_err=4'b1010 with chan_en=4'b1111 -> FAIL next cycle: err_det=1, err_chan=4'b1010, err_first=1; blink rising edges every 4 cycles.
- In RUN, chan_err=4'b0100 with chan_en=4'b1011 -> stays in RUN, err_det=0. test_stop + chan_err=4'b0001 same cycle -> FAIL, err_first=0.
- In FAIL, clear_err together with chan_err=4'b1111 -> IDLE next cycle; err_det=0, seg_en=0, err_chan=0.
- Assert resetn=0 mid-RUN with pass_cnt=5 -> all outputs 0 immediately (asynchronous), state IDLE after release.
